mips_instr_encoder: RTL and testbench

Sequential instruction encoder and program loader for the single-cycle MIPS core: the inverse of the control decoder. It accepts one symbolic instruction per handshake (mnemonic code plus register/immediate fields), packs it into the 32-bit MIPS word the decoder expects, and writes it into instruction memory at a self-incrementing address. A flush request pads the rest of memory with NOPs and then halts, so testbenches and the boot path can build programs without hand-assembled hex.

---
 rtl/mips_instr_encoder.sv | 162 ++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - symbolic MIPS instruction encoder and instruction-memory loader
//
// Accepts one symbolic instruction per in_valid/in_ready handshake, packs it
// into a 32-bit MIPS word and writes it to instruction memory at a
// self-incrementing word address. flush pads the remaining words with NOPs,
// then the loader halts until reset.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid, in_ready             request handshake
//   op, rs, rt, rd, shamt, imm,    symbolic instruction fields
//   target
//   flush                          finish program: pad with NOP, then halt
//   wr_en, wr_addr, wr_data        instruction-memory write port
//   count                          words written so far (instructions + pad)
//   full                           count has reached 2^ADDR_W
//   err                            sticky: an illegal op was accepted
//   done                           padding complete, loader halted

module mips_instr_encoder #(
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        op,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   input  logic              flush,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, WRITE, PAD, DONE} state_t;

   localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

   state_t              state;
   logic [ADDR_W-1:0]   ptr;
   logic [ADDR_W:0]     cnt;
   logic [31:0]         word;
   logic                err_r;

   logic [31:0]         enc;
   logic                legal;
   logic                is_full;

   function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                          input logic [4:0] f_rd, input logic [4:0] f_sh,
                                          input logic [5:0] funct);
      return {6'b000000, f_rs, f_rt, f_rd, f_sh, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] f_rs,
                                          input logic [4:0] f_rt, input logic [15:0] f_imm);
      return {opc, f_rs, f_rt, f_imm};
   endfunction

   // Field forcing: shifts drop rs, jr keeps only rs, other R-types drop shamt,
   // lui drops rs.
   always_comb begin
      enc   = 32'h00000000;
      legal = 1'b1;
      case (op)
         5'd0:    enc = r_word(rs, rt, rd, 5'd0, 6'b100000);
         5'd1:    enc = r_word(rs, rt, rd, 5'd0, 6'b100010);
         5'd2:    enc = r_word(rs, rt, rd, 5'd0, 6'b100100);
         5'd3:    enc = r_word(rs, rt, rd, 5'd0, 6'b100101);
         5'd4:    enc = r_word(rs, rt, rd, 5'd0, 6'b100110);
         5'd5:    enc = r_word(5'd0, rt, rd, shamt, 6'b000000);
         5'd6:    enc = r_word(5'd0, rt, rd, shamt, 6'b000010);
         5'd7:    enc = r_word(5'd0, rt, rd, shamt, 6'b000011);
         5'd8:    enc = r_word(rs, 5'd0, 5'd0, 5'd0, 6'b001000);
         5'd9:    enc = i_word(6'b001000, rs, rt, imm);
         5'd10:   enc = i_word(6'b001100, rs, rt, imm);
         5'd11:   enc = i_word(6'b001101, rs, rt, imm);
         5'd12:   enc = i_word(6'b001110, rs, rt, imm);
         5'd13:   enc = i_word(6'b100011, rs, rt, imm);
         5'd14:   enc = i_word(6'b101011, rs, rt, imm);
         5'd15:   enc = i_word(6'b000100, rs, rt, imm);
         5'd16:   enc = i_word(6'b000101, rs, rt, imm);
         5'd17:   enc = i_word(6'b001111, 5'd0, rt, imm);
         5'd18:   enc = {6'b000010, target};
         5'd19:   enc = {6'b000011, target};
         default: legal = 1'b0;
      endcase
   end

   // count never exceeds 2^ADDR_W, so its MSB alone means "full".
   assign is_full = cnt[ADDR_W];

   // count is bumped on the edge that enters a write cycle, so during the
   // write strobe it already includes the word being written. PAD therefore
   // leaves for DONE once count shows 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= PTR_BASE;
         cnt   <= '0;
         word  <= 32'h00000000;
         err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && !is_full) begin
                  if (legal) begin
                     word  <= enc;
                     cnt   <= cnt + CNT_ONE;
                     state <= WRITE;
                  end else begin
                     err_r <= 1'b1;
                  end
               end else if (flush) begin
                  if (is_full) begin
                     state <= DONE;
                  end else begin
                     cnt   <= cnt + CNT_ONE;
                     state <= PAD;
                  end
               end
            end
            WRITE: begin
               ptr   <= ptr + PTR_ONE;
               state <= IDLE;
            end
            PAD: begin
               ptr <= ptr + PTR_ONE;
               if (is_full) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE) && !is_full && !rst;
   assign wr_en    = (state == WRITE) || (state == PAD);
   assign wr_addr  = ptr;
   assign wr_data  = (state == WRITE) ? word : 32'h00000000;
   assign count    = cnt;
   assign full     = is_full;
   assign err      = err_r;
   assign done     = (state == DONE);

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - directed self-checking bench for mips_instr_encoder
//
// Three instances: u0 (ADDR_W=6, BASE_ADDR=0), u1 (ADDR_W=3, BASE_ADDR=0),
// u2 (ADDR_W=3, BASE_ADDR=6). Instruction fields and rst are shared; each
// instance has its own in_valid and flush.

module tb_mips_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  valid;
   logic [2:0]  fl;
   logic [4:0]  op_s, rs_s, rt_s, rd_s, sh_s;
   logic [15:0] imm_s;
   logic [25:0] tgt_s;

   logic [2:0]  ir, we, fu, er, dn;
   logic [5:0]  wa0;
   logic [2:0]  wa1, wa2;
   logic [31:0] wd0, wd1, wd2;
   logic [6:0]  c0;
   logic [3:0]  c1, c2;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [4:0]  o, a, b, c, s;
      logic [15:0] im;
      logic [25:0] tg;
      logic [31:0] w;
   } vec_t;

   always #5 clk = ~clk;

   mips_instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(valid[0]), .in_ready(ir[0]),
      .op(op_s), .rs(rs_s), .rt(rt_s), .rd(rd_s), .shamt(sh_s), .imm(imm_s), .target(tgt_s),
      .flush(fl[0]), .wr_en(we[0]), .wr_addr(wa0), .wr_data(wd0), .count(c0),
      .full(fu[0]), .err(er[0]), .done(dn[0]));

   mips_instr_encoder #(.ADDR_W(3), .BASE_ADDR(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(valid[1]), .in_ready(ir[1]),
      .op(op_s), .rs(rs_s), .rt(rt_s), .rd(rd_s), .shamt(sh_s), .imm(imm_s), .target(tgt_s),
      .flush(fl[1]), .wr_en(we[1]), .wr_addr(wa1), .wr_data(wd1), .count(c1),
      .full(fu[1]), .err(er[1]), .done(dn[1]));

   mips_instr_encoder #(.ADDR_W(3), .BASE_ADDR(6)) u2 (
      .clk(clk), .rst(rst), .in_valid(valid[2]), .in_ready(ir[2]),
      .op(op_s), .rs(rs_s), .rt(rt_s), .rd(rd_s), .shamt(sh_s), .imm(imm_s), .target(tgt_s),
      .flush(fl[2]), .wr_en(we[2]), .wr_addr(wa2), .wr_data(wd2), .count(c2),
      .full(fu[2]), .err(er[2]), .done(dn[2]));

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; valid = 3'b000; fl = 3'b000;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Waits (bounded) for in_ready, then holds in_valid for exactly one cycle.
   // Returns #1 after the accepting edge, i.e. inside the write cycle.
   task automatic send(input int d, input logic [4:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic [4:0] s, input logic [15:0] im,
                       input logic [25:0] tg);
      int n = 0;
      op_s = o; rs_s = a; rt_s = b; rd_s = c; sh_s = s; imm_s = im; tgt_s = tg;
      while (!ir[d] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (n >= 20) begin
         miscompares++;
         $display("FAIL send_timeout dut=%0d in_ready=%b required=1", d, ir[d]);
      end
      valid[d] = 1'b1;
      @(posedge clk); #1;
      valid[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 3'b000; fl = 3'b000;
      op_s = 5'd0; rs_s = 5'd0; rt_s = 5'd0; rd_s = 5'd0; sh_s = 5'd0; imm_s = 16'h0; tgt_s = 26'h0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (ir[0] !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0", ir[0]); end
      vectors++; if (we[0] !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got=%b exp=0", we[0]); end
      vectors++; if (wa0 !== 6'd0) begin miscompares++; $display("FAIL reset_wr_addr got=%0d exp=0", wa0); end
      vectors++; if (wa2 !== 3'd6) begin miscompares++; $display("FAIL reset_wr_addr_base got=%0d exp=6", wa2); end
      vectors++; if (wd0 !== 32'h0) begin miscompares++; $display("FAIL reset_wr_data got=%h exp=00000000", wd0); end
      vectors++; if (c0 !== 7'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", c0); end
      vectors++; if ({fu[0], er[0], dn[0]} !== 3'b000) begin
         miscompares++; $display("FAIL reset_flags full_err_done got=%b exp=000", {fu[0], er[0], dn[0]}); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got=%b exp=1", ir[0]); end
   endtask

   task automatic test_single_add();
      do_reset();
      send(0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      @(negedge clk);
      vectors++; if (we[0] !== 1'b1) begin miscompares++; $display("FAIL add_wr_en got=%b exp=1", we[0]); end
      vectors++; if (wa0 !== 6'd0) begin miscompares++; $display("FAIL add_wr_addr got=%0d exp=0", wa0); end
      vectors++; if (wd0 !== 32'h00221820) begin miscompares++; $display("FAIL add_wr_data got=%h exp=00221820", wd0); end
      vectors++; if (c0 !== 7'd1) begin miscompares++; $display("FAIL add_count got=%0d exp=1", c0); end
      vectors++; if (ir[0] !== 1'b0) begin miscompares++; $display("FAIL add_in_ready_busy got=%b exp=0", ir[0]); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL add_in_ready_back got=%b exp=1", ir[0]); end
      vectors++; if (we[0] !== 1'b0) begin miscompares++; $display("FAIL add_wr_en_idle got=%b exp=0", we[0]); end
   endtask

   task automatic test_back_to_back();
      vec_t tbl[18];
      tbl[0]  = '{5'd5,  5'd7,  5'd1,  5'd2,  5'd4,  16'h0000, 26'h0,       32'h00011100};
      tbl[1]  = '{5'd9,  5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF, 26'h0,       32'h2022FFFF};
      tbl[2]  = '{5'd15, 5'd1,  5'd2,  5'd0,  5'd0,  16'h0003, 26'h0,       32'h10220003};
      tbl[3]  = '{5'd18, 5'd3,  5'd4,  5'd5,  5'd6,  16'h1111, 26'h10,      32'h08000010};
      tbl[4]  = '{5'd8,  5'd31, 5'd5,  5'd6,  5'd7,  16'h0000, 26'h0,       32'h03E00008};
      tbl[5]  = '{5'd17, 5'd5,  5'd3,  5'd0,  5'd0,  16'h1234, 26'h0,       32'h3C031234};
      tbl[6]  = '{5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  16'h0000, 26'h0,       32'h00432022};
      tbl[7]  = '{5'd19, 5'd1,  5'd1,  5'd1,  5'd1,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
      tbl[8]  = '{5'd6,  5'd1,  5'd9,  5'd10, 5'd31, 16'h0000, 26'h0,       32'h000957C2};
      tbl[9]  = '{5'd7,  5'd9,  5'd1,  5'd1,  5'd1,  16'h0000, 26'h0,       32'h00010843};
      tbl[10] = '{5'd2,  5'd1,  5'd1,  5'd1,  5'd0,  16'h0000, 26'h0,       32'h00210824};
      tbl[11] = '{5'd3,  5'd3,  5'd4,  5'd5,  5'd0,  16'h0000, 26'h0,       32'h00642825};
      tbl[12] = '{5'd4,  5'd8,  5'd9,  5'd10, 5'd0,  16'h0000, 26'h0,       32'h01095026};
      tbl[13] = '{5'd10, 5'd1,  5'd2,  5'd0,  5'd0,  16'h00FF, 26'h0,       32'h302200FF};
      tbl[14] = '{5'd11, 5'd0,  5'd1,  5'd0,  5'd0,  16'hABCD, 26'h0,       32'h3401ABCD};
      tbl[15] = '{5'd12, 5'd2,  5'd3,  5'd0,  5'd0,  16'h0001, 26'h0,       32'h38430001};
      tbl[16] = '{5'd14, 5'd29, 5'd31, 5'd0,  5'd0,  16'h0004, 26'h0,       32'hAFBF0004};
      tbl[17] = '{5'd16, 5'd4,  5'd0,  5'd0,  5'd0,  16'hFFFE, 26'h0,       32'h1480FFFE};
      do_reset();
      for (int i = 0; i < 18; i++) begin
         send(0, tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].im, tbl[i].tg);
         @(negedge clk);
         vectors++; if (we[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_en[%0d] got=%b exp=1", i, we[0]); end
         vectors++; if (wd0 !== tbl[i].w) begin miscompares++; $display("FAIL b2b_wr_data[%0d] op=%0d got=%h exp=%h", i, tbl[i].o, wd0, tbl[i].w); end
         vectors++; if (wa0 !== 6'(i)) begin miscompares++; $display("FAIL b2b_wr_addr[%0d] got=%0d exp=%0d", i, wa0, i); end
         vectors++; if (c0 !== 7'(i + 1)) begin miscompares++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, c0, i + 1); end
      end
   endtask

   task automatic test_illegal();
      do_reset();
      send(0, 5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      @(negedge clk);
      vectors++; if (er[0] !== 1'b1) begin miscompares++; $display("FAIL illegal_err got=%b exp=1", er[0]); end
      vectors++; if (we[0] !== 1'b0) begin miscompares++; $display("FAIL illegal_wr_en got=%b exp=0", we[0]); end
      vectors++; if (c0 !== 7'd0) begin miscompares++; $display("FAIL illegal_count got=%0d exp=0", c0); end
      vectors++; if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL illegal_in_ready got=%b exp=1", ir[0]); end
      send(0, 5'd13, 5'd0, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0);
      @(negedge clk);
      vectors++; if (wd0 !== 32'h8C040008) begin miscompares++; $display("FAIL lw_wr_data got=%h exp=8C040008", wd0); end
      vectors++; if (wa0 !== 6'd0) begin miscompares++; $display("FAIL lw_wr_addr got=%0d exp=0", wa0); end
      vectors++; if (c0 !== 7'd1) begin miscompares++; $display("FAIL lw_count got=%0d exp=1", c0); end
      vectors++; if (er[0] !== 1'b1) begin miscompares++; $display("FAIL lw_err_sticky got=%b exp=1", er[0]); end
   endtask

   task automatic test_pad();
      do_reset();
      for (int i = 0; i < 3; i++) send(1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      @(posedge clk); #1;
      fl[1] = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++; if (we[1] !== 1'b1) begin miscompares++; $display("FAIL pad_wr_en[%0d] got=%b exp=1", i, we[1]); end
         vectors++; if (wa1 !== 3'(3 + i)) begin miscompares++; $display("FAIL pad_wr_addr[%0d] got=%0d exp=%0d", i, wa1, 3 + i); end
         vectors++; if (wd1 !== 32'h0) begin miscompares++; $display("FAIL pad_wr_data[%0d] got=%h exp=00000000", i, wd1); end
         @(posedge clk); #1;
      end
      valid[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++; if (dn[1] !== 1'b1) begin miscompares++; $display("FAIL pad_done[%0d] got=%b exp=1", i, dn[1]); end
         vectors++; if (fu[1] !== 1'b1) begin miscompares++; $display("FAIL pad_full[%0d] got=%b exp=1", i, fu[1]); end
         vectors++; if (ir[1] !== 1'b0) begin miscompares++; $display("FAIL pad_in_ready[%0d] got=%b exp=0", i, ir[1]); end
         vectors++; if (we[1] !== 1'b0) begin miscompares++; $display("FAIL pad_done_wr_en[%0d] got=%b exp=0", i, we[1]); end
         vectors++; if (c1 !== 4'd8) begin miscompares++; $display("FAIL pad_count[%0d] got=%0d exp=8", i, c1); end
         @(posedge clk); #1;
      end
      valid[1] = 1'b0; fl[1] = 1'b0;
   endtask

   task automatic test_base_wrap();
      logic [2:0] exp_addr [8] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(2, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
         @(negedge clk);
         vectors++; if (we[2] !== 1'b1) begin miscompares++; $display("FAIL wrap_wr_en[%0d] got=%b exp=1", i, we[2]); end
         vectors++; if (wa2 !== exp_addr[i]) begin miscompares++; $display("FAIL wrap_wr_addr[%0d] got=%0d exp=%0d", i, wa2, exp_addr[i]); end
      end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (fu[2] !== 1'b1) begin miscompares++; $display("FAIL wrap_full got=%b exp=1", fu[2]); end
      vectors++; if (ir[2] !== 1'b0) begin miscompares++; $display("FAIL wrap_in_ready got=%b exp=0", ir[2]); end
      vectors++; if (c2 !== 4'd8) begin miscompares++; $display("FAIL wrap_count got=%0d exp=8", c2); end
      fl[2] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (dn[2] !== 1'b1) begin miscompares++; $display("FAIL wrap_done got=%b exp=1", dn[2]); end
      vectors++; if (we[2] !== 1'b0) begin miscompares++; $display("FAIL wrap_no_pad got=%b exp=0", we[2]); end
      fl[2] = 1'b0;
   endtask

   task automatic test_flush_priority();
      do_reset();
      op_s = 5'd0; rs_s = 5'd1; rt_s = 5'd2; rd_s = 5'd3; sh_s = 5'd0;
      valid[0] = 1'b1; fl[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      @(negedge clk);
      vectors++; if (we[0] !== 1'b1) begin miscompares++; $display("FAIL prio_wr_en got=%b exp=1", we[0]); end
      vectors++; if (wd0 !== 32'h00221820) begin miscompares++; $display("FAIL prio_wr_data got=%h exp=00221820", wd0); end
      vectors++; if (dn[0] !== 1'b0) begin miscompares++; $display("FAIL prio_done got=%b exp=0", dn[0]); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (we[0] !== 1'b0) begin miscompares++; $display("FAIL prio_idle_wr_en got=%b exp=0", we[0]); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (we[0] !== 1'b1) begin miscompares++; $display("FAIL prio_pad_wr_en got=%b exp=1", we[0]); end
      vectors++; if (wd0 !== 32'h0) begin miscompares++; $display("FAIL prio_pad_data got=%h exp=00000000", wd0); end
      vectors++; if (wa0 !== 6'd1) begin miscompares++; $display("FAIL prio_pad_addr got=%0d exp=1", wa0); end
      vectors++; if (c0 !== 7'd2) begin miscompares++; $display("FAIL prio_pad_count got=%0d exp=2", c0); end
      @(posedge clk); #1;
      rst = 1'b1; fl[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (c0 !== 7'd0) begin miscompares++; $display("FAIL abort_count got=%0d exp=0", c0); end
      vectors++; if (we[0] !== 1'b0) begin miscompares++; $display("FAIL abort_wr_en got=%b exp=0", we[0]); end
      vectors++; if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL abort_in_ready got=%b exp=1", ir[0]); end
      vectors++; if (wa0 !== 6'd0) begin miscompares++; $display("FAIL abort_wr_addr got=%0d exp=0", wa0); end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_illegal();
      test_pad();
      test_base_wrap();
      test_flush_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
